// File: rtl/rvfpm_xif_pkg.sv
// rvfpm_xif_pkg: shared issuer FSM states, id type and default widths
package rvfpm_xif_pkg;
    localparam int X_ID_WIDTH_DEF = 4;
    localparam int XLEN_DEF = 32;
    typedef enum logic [1:0] {IDLE, OFFER, DRAIN} state_t;
    typedef logic [X_ID_WIDTH_DEF-1:0] xif_id_t;
endpackage

// File: rtl/rvfpm_id_scoreboard.sv
// rvfpm_id_scoreboard: in-flight id bitmap with set/clear ports and outstanding counter
module rvfpm_id_scoreboard
    import rvfpm_xif_pkg::*;
#(
    parameter int X_ID_WIDTH = X_ID_WIDTH_DEF,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  set,
    input  logic [X_ID_WIDTH-1:0] set_id,
    input  logic                  clr,
    input  logic [X_ID_WIDTH-1:0] clr_id,
    input  logic [X_ID_WIDTH-1:0] query_id,
    output logic                  query_busy,
    output logic                  clr_hit,
    output logic [CW-1:0]         outstanding
);
    localparam int N = 2 ** X_ID_WIDTH;
    logic [N-1:0] bits;
    logic [N-1:0] bits_n;
    logic         dec;
    assign query_busy = bits[query_id];
    assign clr_hit    = bits[clr_id];
    // a retire with nothing counted (unchecked mode) must not underflow the counter
    assign dec = clr && (outstanding != '0 || set);
    // apply retire clear and issue set to the bitmap in the same cycle
    always_comb begin
        bits_n = bits;
        if (clr) bits_n[clr_id] = 1'b0;
        if (set) bits_n[set_id] = 1'b1;
    end
    // bitmap and counter state; an issue and a retire together leave the count unchanged
    always_ff @(posedge ck) begin
        if (!rst) begin
            bits        <= '0;
            outstanding <= '0;
        end else begin
            bits        <= bits_n;
            outstanding <= outstanding + CW'(set) - CW'(dec);
        end
    end
endmodule

// File: rtl/rvfpm_xif_issuer.sv
// rvfpm_xif_issuer: core-side XIF issuer for rvfpm; RVFPM_ID_CHECK_EN enables id gating and unknown-id detection
module rvfpm_xif_issuer
    import rvfpm_xif_pkg::*;
#(
    parameter int X_ID_WIDTH = X_ID_WIDTH_DEF,
    parameter int XLEN = XLEN_DEF,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instr_in,
    input  logic [XLEN-1:0]       rs1_in,
    output logic                  enable,
    output logic [31:0]           instruction,
    output logic [X_ID_WIDTH-1:0] id,
    output logic [XLEN-1:0]       data_fromXReg,
    input  logic                  fpu_ready,
    input  logic                  toXReg_valid,
    input  logic [X_ID_WIDTH-1:0] id_out,
    input  logic [XLEN-1:0]       data_toXReg,
    output logic                  res_valid,
    output logic [X_ID_WIDTH-1:0] res_id,
    output logic [XLEN-1:0]       res_data,
    input  logic                  flush,
    output logic                  flush_done,
    output logic [CW-1:0]         outstanding,
    output logic                  err_unknown_id,
    output logic [7:0]            err_cnt
);
`ifdef RVFPM_ID_CHECK_EN
    localparam bit ID_CHECK = 1'b1;
`else
    localparam bit ID_CHECK = 1'b0;
`endif
    state_t                state;
    logic [X_ID_WIDTH-1:0] next_id;
    logic                  flush_seen;
    logic                  busy;
    logic                  hit;
    logic                  issue;
    logic                  retire;
    logic                  unknown;
    // enable is only ever high in OFFER, so this is the FPU handshake
    assign issue   = enable && fpu_ready;
    assign retire  = toXReg_valid && (hit || !ID_CHECK);
    assign unknown = ID_CHECK && toXReg_valid && !hit;
    assign instr_ready = rst && state == IDLE && !flush &&
                         int'(outstanding) < MAX_OUTSTANDING && !(ID_CHECK && busy);
    rvfpm_id_scoreboard #(
        .X_ID_WIDTH(X_ID_WIDTH),
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_sb (
        .ck(ck),
        .rst(rst),
        .set(issue),
        .set_id(id),
        .clr(retire),
        .clr_id(id_out),
        .query_id(next_id),
        .query_busy(busy),
        .clr_hit(hit),
        .outstanding(outstanding)
    );
    // issue FSM: accept in IDLE, hold the offer until the FPU takes it, drain on flush
    always_ff @(posedge ck) begin
        if (!rst) begin
            state         <= IDLE;
            enable        <= 1'b0;
            instruction   <= '0;
            id            <= '0;
            data_fromXReg <= '0;
            next_id       <= '0;
            flush_seen    <= 1'b0;
            flush_done    <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        state <= DRAIN;
                    end else if (instr_valid && instr_ready) begin
                        instruction   <= instr_in;
                        data_fromXReg <= rs1_in;
                        id            <= next_id;
                        enable        <= 1'b1;
                        state         <= OFFER;
                    end
                end
                OFFER: begin
                    flush_seen <= flush_seen || flush;
                    if (fpu_ready) begin
                        enable     <= 1'b0;
                        next_id    <= next_id + 1'b1;
                        flush_seen <= 1'b0;
                        state      <= (flush || flush_seen) ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (outstanding == '0) begin
                        flush_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    // completion path: forward retired results and count completions for ids not in flight
    always_ff @(posedge ck) begin
        if (!rst) begin
            res_valid      <= 1'b0;
            res_id         <= '0;
            res_data       <= '0;
            err_unknown_id <= 1'b0;
            err_cnt        <= '0;
        end else begin
            res_valid <= retire;
            if (retire) begin
                res_id   <= id_out;
                res_data <= data_toXReg;
            end
            if (unknown) begin
                err_unknown_id <= 1'b1;
                if (err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
            end
        end
    end
endmodule
